// File: rtl/debounce_edge_detect_pkg.sv
// Project-wide constants shared by the button-conditioning blocks.
package debounce_edge_detect_pkg;
  localparam logic YES = 1'b1;
  localparam logic NO  = 1'b0;
endpackage

// File: rtl/debounce_edge_detect_edge_detect_stage.sv
// Registers a level and emits one-cycle rise/fall strobes, combinational from level and its history.
// History resets to RESET_LEVEL, so there is no strobe when reset is released.
module edge_detect_stage
  import debounce_edge_detect_pkg::*;
#(
  parameter logic RESET_LEVEL = 1'b1
) (
  input  logic clk,
  input  logic reset_low,
  input  logic level,
  output logic pos_edge,
  output logic neg_edge
);

  logic r_level_q;

  always_ff @(posedge clk or negedge reset_low) begin
    if (!reset_low) begin
      r_level_q <= RESET_LEVEL;
    end else begin
      r_level_q <= level;
    end
  end

  assign pos_edge = (level == YES) && (r_level_q == NO);
  assign neg_edge = (level == NO)  && (r_level_q == YES);

endmodule

// File: rtl/debounce_edge_detect.sv
// Raw async input -> 2-flop synchroniser -> CYCLES-sample debounce filter -> edge strobes.
// Step-to-level latency is 2 + CYCLES clocks; edge strobes coincide with the first cycle of the new level.
module debounce_edge_detect
  import debounce_edge_detect_pkg::*;
#(
  parameter int   CYCLES      = 255,
  parameter logic RESET_LEVEL = 1'b1
) (
  input  logic clk,
  input  logic reset_low,
  input  logic bit_in,
  output logic bit_out,
  output logic pos_edge,
  output logic neg_edge
);

  localparam int            CW   = $clog2(CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

  logic [1:0]    r_sync;
  logic [CW-1:0] r_cnt;
  logic          r_bit_out;
  logic          w_s;

  assign w_s = r_sync[1];

  // Counter only advances while s disagrees with the accepted level, so it stops at LAST and never wraps.
  always_ff @(posedge clk or negedge reset_low) begin
    if (!reset_low) begin
      r_sync    <= {2{RESET_LEVEL}};
      r_bit_out <= RESET_LEVEL;
      r_cnt     <= '0;
    end else begin
      r_sync <= {r_sync[0], bit_in};
      if ((w_s ^ r_bit_out) == NO) begin
        r_cnt <= '0;
      end else if (r_cnt == LAST) begin
        r_bit_out <= w_s;
        r_cnt     <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign bit_out = r_bit_out;

  edge_detect_stage #(
    .RESET_LEVEL (RESET_LEVEL)
  ) u_edge (
    .clk       (clk),
    .reset_low (reset_low),
    .level     (r_bit_out),
    .pos_edge  (pos_edge),
    .neg_edge  (neg_edge)
  );

endmodule

// File: tb/tb_debounce_edge_detect.sv
// Drives a CYCLES=4 and a default CYCLES=255 instance; a window-based reference model predicts every cycle.
module tb_debounce_edge_detect;

  localparam int LOGN = 8192;

  logic clk = 1'b0;
  logic reset_low;
  logic b4, b255;
  logic bout4, pos4, neg4;
  logic bout255, pos255, neg255;

  int tests = 0;
  int fails = 0;

  // Reference model state: per-instance log of raw samples and synchronised samples since reset.
  bit blog [2][LOGN];
  bit slog [2][LOGN];
  int n    [2];
  bit lvl  [2];
  bit epos [2];
  bit eneg [2];

  always #5 clk = ~clk;

  debounce_edge_detect #(.CYCLES(4), .RESET_LEVEL(1'b1)) dut4 (
    .clk(clk), .reset_low(reset_low), .bit_in(b4),
    .bit_out(bout4), .pos_edge(pos4), .neg_edge(neg4));

  debounce_edge_detect dut255 (
    .clk(clk), .reset_low(reset_low), .bit_in(b255),
    .bit_out(bout255), .pos_edge(pos255), .neg_edge(neg255));

  task automatic chk(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    tests++;
    assert (obs == exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      n[d] = 0; lvl[d] = 1'b1; epos[d] = 1'b0; eneg[d] = 1'b0;
    end
  endtask

  // A new level is accepted once the last c synchronised samples all differ from the current level.
  task automatic model_edge(input int d, input bit bi, input int c);
    bit s, chg;
    if (n[d] >= LOGN) begin
      $display("FAIL model_log_overflow n=%0d limit=%0d", n[d], LOGN);
      $fatal(1);
    end
    blog[d][n[d]] = bi;
    s = (n[d] >= 2) ? blog[d][n[d]-2] : 1'b1;
    slog[d][n[d]] = s;
    chg = (n[d] + 1 >= c);
    for (int i = 0; i < c; i++)
      if (chg && slog[d][n[d]-i] == lvl[d]) chg = 1'b0;
    epos[d] = chg && s;
    eneg[d] = chg && !s;
    if (chg) lvl[d] = s;
    n[d]++;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge(0, b4, 4);
    model_edge(1, b255, 255);
    #1;
    chk("bout4", bout4, lvl[0]);
    chk("pos4", pos4, epos[0]);
    chk("neg4", neg4, eneg[0]);
    chk("bout255", bout255, lvl[1]);
    chk("pos255", pos255, epos[1]);
    chk("neg255", neg255, eneg[1]);
    chk("excl4", pos4 & neg4, 1'b0);
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    reset_low = 1'b0;
    model_reset();
    #1;
    chk("rst_bout4", bout4, 1'b1);
    chk("rst_bout255", bout255, 1'b1);
    @(negedge clk);
    reset_low = 1'b1;
  endtask

  initial begin
    int k;
    bit stayed;
    reset_low = 1'b0;
    b4 = 1'b0;
    b255 = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_bout4", bout4, 1'b1);
    chk("reset_pos4", pos4, 1'b0);
    chk("reset_neg4", neg4, 1'b0);
    chk("reset_bout255", bout255, 1'b1);
    chk("reset_neg255", neg255, 1'b0);
    @(negedge clk);
    reset_low = 1'b1;
    b4 = 1'b1;
    b255 = 1'b1;
    step();
    chk("post_release_pos4", pos4, 1'b0);
    chk("post_release_neg4", neg4, 1'b0);
    repeat (2) step();

    // Clean press
    b4 = 1'b0;
    k = 0;
    do begin step(); k++; end while (bout4 === 1'b1 && k < 20);
    chk_int("press_latency", k, 6);
    chk("press_neg", neg4, 1'b1);
    step();
    chk("press_neg_one_cycle", neg4, 1'b0);

    // Release after press
    b4 = 1'b1;
    k = 0;
    do begin step(); k++; end while (bout4 === 1'b0 && k < 20);
    chk_int("release_latency", k, 6);
    chk("release_pos", pos4, 1'b1);
    step();
    chk("release_pos_one_cycle", pos4, 1'b0);
    repeat (3) step();

    // Bounce: 3 low, 1 high, 3 low, then high
    stayed = 1'b1;
    for (int i = 0; i < 17; i++) begin
      b4 = (i < 3 || i == 6 || i > 6) ? ((i == 3 || i >= 7) ? 1'b1 : 1'b0) : 1'b0;
      if (i == 3) b4 = 1'b1;
      step();
      if (bout4 !== 1'b1 || neg4 !== 1'b0 || pos4 !== 1'b0) stayed = 1'b0;
    end
    chk("bounce_rejected", stayed, 1'b1);

    // Async reset while counter sits at 2
    b4 = 1'b0;
    repeat (4) step();
    #2;
    reset_low = 1'b0;
    model_reset();
    #1;
    chk("midreset_bout4", bout4, 1'b1);
    chk("midreset_neg4", neg4, 1'b0);
    @(negedge clk);
    reset_low = 1'b1;
    k = 0;
    do begin step(); k++; end while (bout4 === 1'b1 && k < 20);
    chk_int("midreset_fresh_latency", k, 6);
    chk("midreset_fresh_neg", neg4, 1'b1);
    b4 = 1'b1;
    repeat (8) step();

    // Toggling every clock never changes the level
    stayed = 1'b1;
    for (int i = 0; i < 24; i++) begin
      b4 = ~b4;
      step();
      if (bout4 !== 1'b1) stayed = 1'b0;
    end
    chk("toggle_rejected", stayed, 1'b1);
    b4 = 1'b1;
    repeat (4) step();

    // Default CYCLES=255
    b255 = 1'b0;
    k = 0;
    do begin step(); k++; end while (bout255 === 1'b1 && k < 400);
    chk_int("c255_press_latency", k, 257);
    chk("c255_press_neg", neg255, 1'b1);
    b255 = 1'b1;
    k = 0;
    do begin step(); k++; end while (bout255 === 1'b0 && k < 400);
    chk_int("c255_release_latency", k, 257);
    chk("c255_release_pos", pos255, 1'b1);
    b255 = 1'b0;
    repeat (254) step();
    b255 = 1'b1;
    stayed = 1'b1;
    for (int i = 0; i < 300; i++) begin
      step();
      if (bout255 !== 1'b1) stayed = 1'b0;
    end
    chk("c255_254_rejected", stayed, 1'b1);

    // Randomised bursts against the model
    reset_pulse();
    for (int seg = 0; seg < 40; seg++) begin
      int len4, len255;
      b255 = 1'($urandom_range(0, 1));
      len255 = $urandom_range(1, 300);
      for (int i = 0; i < len255 && n[0] < LOGN - 16; i++) begin
        if (len4 == 0 || i % len4 == 0) begin
          b4 = 1'($urandom_range(0, 1));
          len4 = $urandom_range(1, 8);
        end
        step();
      end
      if (n[0] >= LOGN - 400) reset_pulse();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
